// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline register with branch/jump resolution.
// A taken redirect opens a two-capture squash window that turns younger slots into bubbles.
module ex_mem_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        in_valid,
  input  logic        in_ctrl_regwrt,
  input  logic        in_ctrl_memtoreg,
  input  logic        in_ctrl_memrd,
  input  logic        in_ctrl_memwrt,
  input  logic        in_ctrl_branch,
  input  logic        in_ctrl_btype,
  input  logic        in_ctrl_jump,
  input  logic [31:0] in_alu_result,
  input  logic        in_alu_z,
  input  logic        in_alu_n,
  input  logic [31:0] in_rt,
  input  logic [5:0]  in_rd,
  input  logic [31:0] in_target,
  output logic        out_valid,
  output logic        out_ctrl_regwrt,
  output logic        out_ctrl_memtoreg,
  output logic        out_ctrl_memrd,
  output logic        out_ctrl_memwrt,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_rt,
  output logic [5:0]  out_rd,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        squash
);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    SQ2 = 2'd1,
    SQ1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic capture_c;
  logic live_c;
  logic cond_c;
  logic taken_c;

  assign capture_c = ~stall;
  assign live_c    = in_valid & (state == RUN);
  assign cond_c    = in_ctrl_btype ? in_alu_n : in_alu_z;
  // Jump overrides the branch condition; flags only matter for a branch.
  assign taken_c   = live_c & (in_ctrl_jump | (in_ctrl_branch & cond_c));
  assign squash    = (state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (capture_c) begin
      unique case (state)
        RUN:     state_nxt = taken_c ? SQ2 : RUN;
        SQ2:     state_nxt = SQ1;
        SQ1:     state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Pipeline payload; controls are gated so a bubble never writes anything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_ctrl_regwrt   <= 1'b0;
      out_ctrl_memtoreg <= 1'b0;
      out_ctrl_memrd    <= 1'b0;
      out_ctrl_memwrt   <= 1'b0;
      out_alu_result    <= 32'd0;
      out_rt            <= 32'd0;
      out_rd            <= 6'd0;
      redirect          <= 1'b0;
      redirect_pc       <= 32'd0;
    end else if (capture_c) begin
      out_valid         <= live_c;
      out_ctrl_regwrt   <= in_ctrl_regwrt & live_c;
      out_ctrl_memtoreg <= in_ctrl_memtoreg & live_c;
      out_ctrl_memrd    <= in_ctrl_memrd & live_c;
      out_ctrl_memwrt   <= in_ctrl_memwrt & live_c;
      out_alu_result    <= in_alu_result;
      out_rt            <= in_rt;
      out_rd            <= in_rd;
      redirect          <= taken_c;
      if (taken_c) redirect_pc <= in_target;
    end else begin
      redirect          <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Bench for ex_mem_buffer: a kill-counter reference model checked every negedge,
// plus directed literal checks after selected capture edges.
module tb_ex_mem_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        in_valid;
  logic        in_ctrl_regwrt, in_ctrl_memtoreg, in_ctrl_memrd, in_ctrl_memwrt;
  logic        in_ctrl_branch, in_ctrl_btype, in_ctrl_jump;
  logic [31:0] in_alu_result;
  logic        in_alu_z, in_alu_n;
  logic [31:0] in_rt;
  logic [5:0]  in_rd;
  logic [31:0] in_target;
  logic        out_valid;
  logic        out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_memrd, out_ctrl_memwrt;
  logic [31:0] out_alu_result;
  logic [31:0] out_rt;
  logic [5:0]  out_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        squash;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  ex_mem_buffer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .in_valid(in_valid),
    .in_ctrl_regwrt(in_ctrl_regwrt), .in_ctrl_memtoreg(in_ctrl_memtoreg),
    .in_ctrl_memrd(in_ctrl_memrd), .in_ctrl_memwrt(in_ctrl_memwrt),
    .in_ctrl_branch(in_ctrl_branch), .in_ctrl_btype(in_ctrl_btype),
    .in_ctrl_jump(in_ctrl_jump), .in_alu_result(in_alu_result),
    .in_alu_z(in_alu_z), .in_alu_n(in_alu_n), .in_rt(in_rt), .in_rd(in_rd),
    .in_target(in_target), .out_valid(out_valid),
    .out_ctrl_regwrt(out_ctrl_regwrt), .out_ctrl_memtoreg(out_ctrl_memtoreg),
    .out_ctrl_memrd(out_ctrl_memrd), .out_ctrl_memwrt(out_ctrl_memwrt),
    .out_alu_result(out_alu_result), .out_rt(out_rt), .out_rd(out_rd),
    .redirect(redirect), .redirect_pc(redirect_pc), .squash(squash)
  );

  always #5 clk = ~clk;

  // Reference model: kill counts how many upcoming captures must become bubbles.
  int          m_kill;
  logic        m_valid, m_regwrt, m_memtoreg, m_memrd, m_memwrt, m_redirect;
  logic [31:0] m_alu, m_rt, m_pc;
  logic [5:0]  m_rd;
  logic        m_live, m_taken;

  assign m_live  = in_valid && (m_kill == 0);
  assign m_taken = m_live && (in_ctrl_jump ||
                   (in_ctrl_branch && ((in_ctrl_btype == 1'b1) ? in_alu_n : in_alu_z)));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kill <= 0; m_valid <= 0; m_regwrt <= 0; m_memtoreg <= 0; m_memrd <= 0;
      m_memwrt <= 0; m_redirect <= 0; m_alu <= 0; m_rt <= 0; m_pc <= 0; m_rd <= 0;
    end else if (stall) begin
      m_redirect <= 1'b0;
    end else begin
      m_valid    <= m_live;
      m_regwrt   <= m_live && in_ctrl_regwrt;
      m_memtoreg <= m_live && in_ctrl_memtoreg;
      m_memrd    <= m_live && in_ctrl_memrd;
      m_memwrt   <= m_live && in_ctrl_memwrt;
      m_alu      <= in_alu_result;
      m_rt       <= in_rt;
      m_rd       <= in_rd;
      m_redirect <= m_taken;
      if (m_taken) m_pc <= in_target;
      if (m_kill > 0) m_kill <= m_kill - 1;
      else if (m_taken) m_kill <= 2;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.out_valid", 32'(out_valid), 32'(m_valid));
      chk("m.regwrt", 32'(out_ctrl_regwrt), 32'(m_regwrt));
      chk("m.memtoreg", 32'(out_ctrl_memtoreg), 32'(m_memtoreg));
      chk("m.memrd", 32'(out_ctrl_memrd), 32'(m_memrd));
      chk("m.memwrt", 32'(out_ctrl_memwrt), 32'(m_memwrt));
      chk("m.alu_result", out_alu_result, m_alu);
      chk("m.rt", out_rt, m_rt);
      chk("m.rd", 32'(out_rd), 32'(m_rd));
      chk("m.redirect", 32'(redirect), 32'(m_redirect));
      chk("m.redirect_pc", redirect_pc, m_pc);
      chk("m.squash", 32'(squash), 32'(m_kill != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    stall = 0; in_valid = 0; in_ctrl_regwrt = 0; in_ctrl_memtoreg = 0;
    in_ctrl_memrd = 0; in_ctrl_memwrt = 0; in_ctrl_branch = 0; in_ctrl_btype = 0;
    in_ctrl_jump = 0; in_alu_result = 0; in_alu_z = 0; in_alu_n = 0;
    in_rt = 0; in_rd = 0; in_target = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    repeat (2) tick();
    cmp_en = 1'b1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.squash", 32'(squash), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset.out_valid", 32'(out_valid), 32'd0);

    // Pass-through
    in_valid = 1; in_ctrl_regwrt = 1; in_ctrl_memwrt = 1;
    in_alu_result = 32'h0000_00A5; in_rd = 6'd7; in_rt = 32'h1234_5678;
    tick();
    chk("pass.out_valid", 32'(out_valid), 32'd1);
    chk("pass.alu", out_alu_result, 32'h0000_00A5);
    chk("pass.rd", 32'(out_rd), 32'd7);
    chk("pass.rt", out_rt, 32'h1234_5678);
    chk("pass.redirect", 32'(redirect), 32'd0);

    // Asynchronous reset in the middle of a cycle
    #2 rst_n = 1'b0;
    #1;
    chk("areset.out_valid", 32'(out_valid), 32'd0);
    chk("areset.alu", out_alu_result, 32'd0);
    chk("areset.rd", 32'(out_rd), 32'd0);
    chk("areset.regwrt", 32'(out_ctrl_regwrt), 32'd0);
    chk("areset.squash", 32'(squash), 32'd0);
    #2 rst_n = 1'b1;

    // Branch-if-zero taken, then two bubbles, then a live slot
    clr_in();
    in_valid = 1; in_ctrl_branch = 1; in_alu_z = 1; in_target = 32'h0000_0040;
    in_ctrl_regwrt = 1; in_alu_result = 32'd3;
    tick();
    chk("bz.redirect", 32'(redirect), 32'd1);
    chk("bz.redirect_pc", redirect_pc, 32'h0000_0040);
    chk("bz.squash", 32'(squash), 32'd1);
    clr_in();
    in_valid = 1; in_ctrl_regwrt = 1; in_alu_result = 32'h11;
    tick();
    chk("bz.bubble1.valid", 32'(out_valid), 32'd0);
    chk("bz.bubble1.regwrt", 32'(out_ctrl_regwrt), 32'd0);
    chk("bz.bubble1.redirect", 32'(redirect), 32'd0);
    tick();
    chk("bz.bubble2.valid", 32'(out_valid), 32'd0);
    chk("bz.bubble2.squash", 32'(squash), 32'd0);
    tick();
    chk("bz.third.valid", 32'(out_valid), 32'd1);
    chk("bz.third.regwrt", 32'(out_ctrl_regwrt), 32'd1);

    // Branch-if-negative not taken (z set must not matter)
    clr_in();
    in_valid = 1; in_ctrl_branch = 1; in_ctrl_btype = 1; in_alu_z = 1;
    tick();
    chk("bn_nt.redirect", 32'(redirect), 32'd0);
    chk("bn_nt.squash", 32'(squash), 32'd0);
    chk("bn_nt.valid", 32'(out_valid), 32'd1);

    // Branch-if-negative taken
    in_alu_n = 1; in_target = 32'h0000_0080;
    tick();
    chk("bn_t.redirect", 32'(redirect), 32'd1);
    chk("bn_t.redirect_pc", redirect_pc, 32'h0000_0080);
    clr_in();
    repeat (2) tick();

    // Flags without branch/jump are ignored
    in_valid = 1; in_alu_z = 1; in_alu_n = 1; in_target = 32'hDEAD_0000;
    tick();
    chk("flags.redirect", 32'(redirect), 32'd0);
    chk("flags.pc_hold", redirect_pc, 32'h0000_0080);

    // Jump beats a failing branch condition
    in_alu_z = 0; in_ctrl_branch = 1; in_ctrl_jump = 1; in_target = 32'h0000_0100;
    tick();
    chk("jwin.redirect", 32'(redirect), 32'd1);
    chk("jwin.redirect_pc", redirect_pc, 32'h0000_0100);
    clr_in();
    repeat (2) tick();

    // Jump in an invalid slot does nothing
    in_ctrl_jump = 1; in_target = 32'h0000_0111;
    tick();
    chk("ijump.redirect", 32'(redirect), 32'd0);
    chk("ijump.valid", 32'(out_valid), 32'd0);

    // Taken jump held off by stall for three edges
    clr_in();
    stall = 1; in_valid = 1; in_ctrl_jump = 1; in_target = 32'h0000_0200;
    in_alu_result = 32'h55;
    repeat (3) begin
      tick();
      chk("stall.redirect", 32'(redirect), 32'd0);
      chk("stall.valid_hold", 32'(out_valid), 32'd0);
      chk("stall.squash", 32'(squash), 32'd0);
    end
    stall = 0;
    tick();
    chk("stall.rel.redirect", 32'(redirect), 32'd1);
    chk("stall.rel.pc", redirect_pc, 32'h0000_0200);
    chk("stall.rel.alu", out_alu_result, 32'h55);
    // Stall during SQ2 keeps squash asserted and outputs frozen
    clr_in();
    stall = 1; in_valid = 1; in_ctrl_regwrt = 1;
    repeat (2) begin
      tick();
      chk("sq2stall.squash", 32'(squash), 32'd1);
      chk("sq2stall.redirect", 32'(redirect), 32'd0);
      chk("sq2stall.valid_hold", 32'(out_valid), 32'd1);
    end
    stall = 0;
    tick();
    chk("sq1.valid", 32'(out_valid), 32'd0);
    chk("sq1.squash", 32'(squash), 32'd1);

    // Second jump arriving in SQ1 is ignored
    in_ctrl_jump = 1; in_target = 32'h0000_0300;
    tick();
    chk("sq1jump.redirect", 32'(redirect), 32'd0);
    chk("sq1jump.valid", 32'(out_valid), 32'd0);
    chk("sq1jump.squash", 32'(squash), 32'd0);
    chk("sq1jump.pc", redirect_pc, 32'h0000_0200);
    in_ctrl_jump = 0;
    tick();
    chk("sq1jump.after.valid", 32'(out_valid), 32'd1);

    // Reset abandons a squash window
    in_ctrl_jump = 1; in_target = 32'h0000_0400;
    tick();
    chk("rsq.squash_pre", 32'(squash), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rsq.squash", 32'(squash), 32'd0);
    chk("rsq.redirect", 32'(redirect), 32'd0);
    #2 rst_n = 1'b1;
    clr_in();
    in_valid = 1; in_alu_result = 32'h77;
    tick();
    chk("rsq.first.valid", 32'(out_valid), 32'd1);
    chk("rsq.first.alu", out_alu_result, 32'h77);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 80; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 4) != 0);
      in_ctrl_regwrt = 1'($urandom); in_ctrl_memtoreg = 1'($urandom);
      in_ctrl_memrd = 1'($urandom); in_ctrl_memwrt = 1'($urandom);
      in_ctrl_branch = 1'($urandom); in_ctrl_btype = 1'($urandom);
      in_ctrl_jump = ($urandom_range(0, 5) == 0);
      in_alu_z = 1'($urandom); in_alu_n = 1'($urandom);
      in_alu_result = $urandom; in_rt = $urandom; in_rd = 6'($urandom);
      in_target = $urandom;
      tick();
    end

    clr_in();
    tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
